port_request_queue: RTL and testbench

//  Per-port request FIFO placed directly upstream of one port of the triple-ported memory; three instances, one per port.

---
 rtl/tpm_pkg.sv | 14 +
 rtl/port_request_queue_if.sv | 30 +++
 rtl/req_fifo_mem.sv | 25 ++
 rtl/port_request_queue.sv | 107 ++++++++++
 tb/tb_port_request_queue.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/tpm_pkg.sv
// Shared triple-ported-memory types.
// Used by the request queues and the memory-side blocks.
package tpm_pkg;

  localparam int TPM_ADDR_W = 12;
  localparam int TPM_DATA_W = 16;

  typedef struct packed {
    logic [TPM_ADDR_W-1:0] addr;
    logic [TPM_DATA_W-1:0] data;
    logic                  wen;
  } tpm_req_t;

endpackage

// File: rtl/port_request_queue_if.sv
// Client-side valid/ready request channel.
// master drives requests; slave is the queue.
interface port_request_queue_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_wen;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    output req_wen,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    input  req_wen,
    output req_ready
  );

endinterface

// File: rtl/req_fifo_mem.sv
// Request storage: registered write port, combinational read.
// Storage is intentionally not reset.
module req_fifo_mem
  import tpm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  tpm_req_t         wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output tpm_req_t         rd_data
);

  tpm_req_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/port_request_queue.sv
// Per-port request FIFO in front of the triple-ported memory.
// Optional stats counters with REQ_QUEUE_STATS_EN.
module port_request_queue
  import tpm_pkg::*;
#(
  parameter int ADDR_W = TPM_ADDR_W,
  parameter int DATA_W = TPM_DATA_W,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  port_request_queue_if.slave req,
  input  logic              flush,
  input  logic              freeze_inputs,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wen,
  output logic              mem_valid_in,
`ifdef REQ_QUEUE_STATS_EN
  output logic [15:0]       stall_cycles,
  output logic [PTR_W:0]    high_water,
`endif
  output logic [PTR_W:0]    occupancy
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  tpm_req_t         wr_ent;
  tpm_req_t         head;
  tpm_req_t         last_head;
  tpm_req_t         sel;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = req.req_valid && !full && !flush;
  assign pop   = !freeze_inputs && !empty && !flush;

  assign req.req_ready = !full;

  assign wr_ent.addr = req.req_addr;
  assign wr_ent.data = req.req_data;
  assign wr_ent.wen  = req.req_wen;

  req_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_ent),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push}
                     - {{PTR_W{1'b0}}, pop};
    end
  end

  // Keeps address/data steady on the port while empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    last_head <= '0;
    else if (pop) last_head <= head;
  end

  assign sel          = empty ? last_head : head;
  assign mem_addr     = sel.addr;
  assign mem_data_in  = sel.data;
  assign mem_wen      = !empty && head.wen;
  assign mem_valid_in = !empty;
  assign occupancy    = count;

`ifdef REQ_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      high_water   <= '0;
    end else begin
      if (!empty && freeze_inputs &&
          stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (count > high_water)
        high_water <= count;
    end
  end
`endif

endmodule

// File: tb/tb_port_request_queue.sv
// Directed bench for port_request_queue.
// Scoreboard queue tracks expected FIFO contents.
module tb_port_request_queue;
  import tpm_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        freeze_inputs;
  logic [11:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_wen;
  logic        mem_valid_in;
  logic [2:0]  occupancy;
`ifdef REQ_QUEUE_STATS_EN
  logic [15:0] stall_cycles;
  logic [2:0]  high_water;
`endif

  int checks = 0;
  int errors = 0;
  tpm_req_t sb [$];
  tpm_req_t last_m;
  int stall_m;
  int hw_m;

  port_request_queue_if #(.ADDR_W(12), .DATA_W(16)) rif ();

  port_request_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (rif),
    .flush         (flush),
    .freeze_inputs (freeze_inputs),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_wen       (mem_wen),
    .mem_valid_in  (mem_valid_in),
`ifdef REQ_QUEUE_STATS_EN
    .stall_cycles  (stall_cycles),
    .high_water    (high_water),
`endif
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic        v,
                      input logic [11:0] a,
                      input logic [15:0] d,
                      input logic        w,
                      input logic        fz,
                      input logic        fl);
    int n;
    tpm_req_t e;
    @(negedge clk);
    rif.req_valid = v;
    rif.req_addr  = a;
    rif.req_data  = d;
    rif.req_wen   = w;
    freeze_inputs = fz;
    flush         = fl;
    #1;
    n = sb.size();
    chk("req_ready", 32'(rif.req_ready), 32'(n < 4));
    chk("mem_valid", 32'(mem_valid_in), 32'(n != 0));
    chk("occupancy", 32'(occupancy), 32'(n));
    if (n != 0) begin
      e = sb[0];
      chk("head_addr", 32'(mem_addr), 32'(e.addr));
      chk("head_data", 32'(mem_data_in), 32'(e.data));
      chk("head_wen", 32'(mem_wen), 32'(e.wen));
    end else begin
      chk("empty_wen", 32'(mem_wen), 32'd0);
      chk("hold_addr", 32'(mem_addr), 32'(last_m.addr));
      chk("hold_data", 32'(mem_data_in),
          32'(last_m.data));
    end
    if (n != 0 && fz) stall_m++;
    if (n > hw_m) hw_m = n;
    if (fl) begin
      sb.delete();
    end else begin
      if (!fz && n != 0) last_m = sb.pop_front();
      if (v && n < 4) begin
        e.addr = a;
        e.data = d;
        e.wen  = w;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic fz);
    step(1'b0, 12'h0, 16'h0, 1'b0, fz, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    freeze_inputs = 1'b0;
    rif.req_valid = 1'b0;
    rif.req_addr  = '0;
    rif.req_data  = '0;
    rif.req_wen   = 1'b0;
    last_m        = '0;
    stall_m       = 0;
    hw_m          = 0;
    #3;
    chk("rst_ready", 32'(rif.req_ready), 32'd1);
    chk("rst_valid", 32'(mem_valid_in), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data_in), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: single push, next-cycle visibility, pop
    step(1'b1, 12'h010, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // 2: freeze while filling, then drain
    step(1'b1, 12'h101, 16'h1111, 1'b1, 1'b1, 1'b0);
    step(1'b1, 12'h102, 16'h2222, 1'b0, 1'b1, 1'b0);
    step(1'b1, 12'h103, 16'h3333, 1'b1, 1'b1, 1'b0);
    step(1'b1, 12'h104, 16'h4444, 1'b0, 1'b1, 1'b0);
    step(1'b1, 12'h105, 16'h5555, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // 3: full queue, pop with refused push
    for (int i = 0; i < 4; i++)
      step(1'b1, 12'(12'h200 + i), 16'(16'hA000 + i),
           1'b1, 1'b1, 1'b0);
    step(1'b1, 12'h2FF, 16'hF00D, 1'b1, 1'b0, 1'b0);
    step(1'b1, 12'h2FF, 16'hF00D, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // 4: wrap-around with push/pop pairs
    step(1'b1, 12'h300, 16'hC000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++)
      step(1'b1, 12'(12'h300 + i), 16'(16'hC000 + i),
           1'(i % 2), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) idle(1'b0);

    // 5: flush beats a simultaneous push
    for (int i = 0; i < 3; i++)
      step(1'b1, 12'(12'h400 + i), 16'(16'hD000 + i),
           1'b1, 1'b1, 1'b0);
    step(1'b1, 12'h4EE, 16'hDEAD, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // 6: async reset mid-drain
    for (int i = 0; i < 3; i++)
      step(1'b1, 12'(12'h500 + i), 16'(16'hE000 + i),
           1'b1, 1'b1, 1'b0);
    idle(1'b0);
    @(negedge clk);
    rif.req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(mem_valid_in), 32'd0);
    chk("arst_wen", 32'(mem_wen), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_data", 32'(mem_data_in), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_ready", 32'(rif.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    last_m  = '0;
    stall_m = 0;
    hw_m    = 0;

    step(1'b1, 12'h600, 16'h6060, 1'b1, 1'b1, 1'b0);
    step(1'b1, 12'h601, 16'h6161, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    idle(1'b0);
`ifdef REQ_QUEUE_STATS_EN
    chk("stall_model", 32'(stall_m), 32'd7);
    chk("stall_cycles", 32'(stall_cycles), 32'(stall_m));
    chk("high_water", 32'(high_water), 32'(hw_m));
`endif
    for (int i = 0; i < 2; i++) idle(1'b0);
`ifdef REQ_QUEUE_STATS_EN
    chk("stall_hold", 32'(stall_cycles), 32'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
